sa_tile_sched: RTL and testbench
================================

Name: sa_tile_sched

Overview:
Tile-level scheduler for the weight-stationary systolic array. Per tile it sequences weight preload, activation streaming, pipeline flush and partial-sum drain, then repeats for a configured number of tiles. It drives the array's weight/psum mode select (ctrl_out) and the per-phase enables. It sits between the top-level command interface and the array/buffer datapath.

Parameters:
N, 8, array dimension (rows = columns = N)
LEN_W, 16, width of the activation-length and tile-count config fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a job; sampled only in IDLE
cfg_num_tiles  in  LEN_W  tiles per job; latched on accepted start
cfg_act_len  in  LEN_W  activation rows per tile; latched on accepted start
abort  in  1  terminate the job at the next cycle boundary
w_valid  in  1  weight buffer presents one weight row
act_valid  in  1  activation buffer presents one row
out_ready  in  1  output buffer accepts one psum row
ctrl_out  out  1  array mode select: 1 = weight load, 0 = compute/psum
w_ld_en  out  1  weight row is transferred this cycle
act_en  out  1  activation row is transferred this cycle
drain_en  out  1  psum row is transferred this cycle
tile_idx  out  LEN_W  index of the current tile
busy  out  1  high in every state except IDLE
exit  out  1  one-cycle pulse when a job ends (normal, zero-tile or abort)

Behaviour:
- Reset: state=IDLE. All outputs are 0, and all counters and latched config are 0. Reset has priority over abort and start.
- The FSM is registered. The enables are combinational from state and handshakes.
- IDLE: on start, latch cfg_*, tile_idx<=0. If cfg_num_tiles==0, go to FIN. Otherwise go to LOAD_W.
- LOAD_W: ctrl_out=1 and w_ld_en=w_valid. The row counter increments per transfer. After the N-th transfer, go to STREAM (ctrl_out falls the following cycle). If w_valid stays low, remain in LOAD_W.
- STREAM: ctrl_out=0 and act_en=act_valid. Count transfers. After the cfg_act_len-th transfer, go to FLUSH. If cfg_act_len==0, the state lasts 1 cycle with no transfers.
- FLUSH: fixed wait of 2N-1 cycles with all enables 0, for skew and pipeline drain. Then go to DRAIN.
- DRAIN: drain_en=out_ready. After N transfers:
  - if tile_idx==cfg_num_tiles-1, go to FIN;
  - otherwise tile_idx+1 and go to LOAD_W.
- FIN: exit=1 for exactly one cycle, then go to IDLE. busy is high in FIN.
- abort in any non-IDLE state: the next state is FIN.
  - Handshakes in the abort cycle are still honoured: enables follow the current state.
  - Counters clear on FIN entry.
- start outside IDLE is ignored. The cfg inputs are ignored except on an accepted start.
- Counters are LEN_W bits wide. A cfg_act_len of 2^LEN_W-1 must not wrap before the compare.
- Latency:
  - start to first w_ld_en: 1 cycle, when w_valid is high.
  - Minimum tile with no stalls: N + cfg_act_len + (2N-1) + N cycles.
- Back-to-back jobs: start is accepted in the cycle IDLE is re-entered after FIN.

Test Plan:
- N=4, tiles=1, act_len=3, all valids and ready held high: w_ld_en high 4 cycles, act_en 3, 7 idle cycles, drain_en 4, exit pulses once at cycle 19 after start, busy 19 cycles.
- tiles=3, act_len=2: tile_idx steps 0→1→2; ctrl_out rises 3 times; exit pulses once only after the third drain.
- Stalls: toggle w_valid, act_valid and out_ready at 50% → transfer counts still exactly 4/act_len/4 per tile; no enable while its handshake input is low.
- cfg_num_tiles=0 with start → exit pulses the cycle after start; no enable ever asserted. act_len=0 → STREAM lasts 1 cycle with act_en=0.
- abort in STREAM at the 2nd row → FIN next cycle, exit pulse, IDLE after. A new start is then accepted and tile_idx restarts at 0.
- Assert rst in DRAIN → next cycle all outputs 0 and state IDLE. start in the same cycle as rst is ignored.

Source files
------------

// File: rtl/sa_tile_sched.sv
// sa_tile_sched: tile-level scheduler for the weight-stationary systolic array.
// For each tile of a job it runs weight preload, activation streaming, a fixed
// pipeline flush and a partial-sum drain, then repeats until cfg_num_tiles
// tiles are done or the job is aborted.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           one-cycle job request, only accepted while idle
//   cfg_num_tiles   tiles per job, latched on an accepted start
//   cfg_act_len     activation rows per tile, latched on an accepted start
//   abort           ends the current job through FIN at the next cycle boundary
//   w_valid         weight buffer has a row available
//   act_valid       activation buffer has a row available
//   out_ready       output buffer can take a psum row
//   ctrl_out        array mode: 1 = weight load, 0 = compute/psum
//   w_ld_en         weight row transferred this cycle
//   act_en          activation row transferred this cycle
//   drain_en        psum row transferred this cycle
//   tile_idx        index of the tile being processed
//   busy            high in every state except idle
//   exit            one-cycle pulse when a job ends
module sa_tile_sched #(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_num_tiles,
    input  logic [LEN_W-1:0] cfg_act_len,
    input  logic             abort,
    input  logic             w_valid,
    input  logic             act_valid,
    input  logic             out_ready,
    output logic             ctrl_out,
    output logic             w_ld_en,
    output logic             act_en,
    output logic             drain_en,
    output logic [LEN_W-1:0] tile_idx,
    output logic             busy,
    output logic             exit
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StFlush,
        StDrain,
        StFin
    } state_e;

    localparam logic [LEN_W-1:0] RowLast   = LEN_W'(N - 1);
    localparam logic [LEN_W-1:0] FlushLast = LEN_W'(2 * N - 2);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] tile_q, tile_d;
    logic [LEN_W-1:0] num_tiles_q, num_tiles_d;
    logic [LEN_W-1:0] act_len_q, act_len_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_d      = tile_q;
        num_tiles_d = num_tiles_q;
        act_len_d   = act_len_q;
        ctrl_out    = 1'b0;
        w_ld_en     = 1'b0;
        act_en      = 1'b0;
        drain_en    = 1'b0;
        exit        = 1'b0;
        busy        = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_tiles_d = cfg_num_tiles;
                    act_len_d   = cfg_act_len;
                    tile_d      = '0;
                    cnt_d       = '0;
                    state_d     = (cfg_num_tiles == '0) ? StFin : StLoadW;
                end
            end
            StLoadW: begin
                ctrl_out = 1'b1;
                w_ld_en  = w_valid;
                if (w_valid) begin
                    if (cnt_q == RowLast) begin
                        cnt_d   = '0;
                        state_d = StStream;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StStream: begin
                if (act_len_q == '0) begin
                    // Empty tile: one pass-through cycle, no transfers.
                    state_d = StFlush;
                    cnt_d   = '0;
                end else begin
                    act_en = act_valid;
                    if (act_valid) begin
                        // Compare against len-1 so a full-range length never wraps the counter.
                        if (cnt_q == act_len_q - LEN_W'(1)) begin
                            cnt_d   = '0;
                            state_d = StFlush;
                        end else begin
                            cnt_d = cnt_q + LEN_W'(1);
                        end
                    end
                end
            end
            StFlush: begin
                // 2N-1 cycles lets the skewed wavefront leave the array.
                if (cnt_q == FlushLast) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            StDrain: begin
                drain_en = out_ready;
                if (out_ready) begin
                    if (cnt_q == RowLast) begin
                        cnt_d = '0;
                        if (tile_q == num_tiles_q - LEN_W'(1)) begin
                            state_d = StFin;
                        end else begin
                            tile_d  = tile_q + LEN_W'(1);
                            state_d = StLoadW;
                        end
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StFin: begin
                exit    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any phase transition; this cycle's transfers still count.
        if (abort && (state_q != StIdle)) begin
            state_d = StFin;
            cnt_d   = '0;
            tile_d  = tile_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tile_q      <= '0;
            num_tiles_q <= '0;
            act_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_q      <= tile_d;
            num_tiles_q <= num_tiles_d;
            act_len_q   <= act_len_d;
        end
    end

    assign tile_idx = tile_q;

endmodule

// File: tb/tb_sa_tile_sched.sv
module tb_sa_tile_sched;

    localparam int N  = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, w_valid, act_valid, out_ready;
    logic [LW-1:0] cfg_num_tiles, cfg_act_len;
    logic          ctrl_out, w_ld_en, act_en, drain_en, busy, exit;
    logic [LW-1:0] tile_idx;

    sa_tile_sched #(.N(N), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_num_tiles(cfg_num_tiles),
        .cfg_act_len  (cfg_act_len),
        .abort        (abort),
        .w_valid      (w_valid),
        .act_valid    (act_valid),
        .out_ready    (out_ready),
        .ctrl_out     (ctrl_out),
        .w_ld_en      (w_ld_en),
        .act_en       (act_en),
        .drain_en     (drain_en),
        .tile_idx     (tile_idx),
        .busy         (busy),
        .exit         (exit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tiles;
        int len;
        int pw;
        int pa;
        int po;
        int ab_at;   // job cycle in which abort is raised, -1 for none
        int e_exit;  // expected exit cycle after start, -1 = not fixed
        int e_w;
        int e_a;
        int e_d;
    } vec_t;

    vec_t tbl[9];

    int errors = 0;
    int checks = 0;

    // Reference-model state: job progress is tracked by the procedural phase
    // walk in run_job, these hold what the outside world should see.
    int  job_cyc, abort_at, m_tidx;
    bit  ab, in_job;
    int  mod_w, mod_a, mod_d, mod_loads;
    int  dut_w, dut_a, dut_d, dut_rise, dut_exits, dut_exit_cyc;
    logic prev_ctrl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (job cycle %0d, t=%0t)",
                     nm, act, exp, job_cyc, $time);
        end
    endtask

    function automatic logic coin(input int pct);
        return ($urandom_range(1, 100) <= pct);
    endfunction

    // Randomise handshakes, plus start/cfg noise that a busy scheduler must ignore.
    task automatic drive(input int pw, input int pa, input int po);
        w_valid       = coin(pw);
        act_valid     = coin(pa);
        out_ready     = coin(po);
        start         = coin(50);
        cfg_num_tiles = LW'($urandom);
        cfg_act_len   = LW'($urandom);
    endtask

    // One clock cycle: check outputs mid-cycle, then advance to the next negedge.
    task automatic cyc(input logic e_ctrl, input logic e_w, input logic e_a, input logic e_d,
                       input logic e_busy, input logic e_exit);
        abort = in_job && (job_cyc == abort_at);
        #1;
        chk("ctrl_out", ctrl_out, e_ctrl);
        chk("w_ld_en", w_ld_en, e_w);
        chk("act_en", act_en, e_a);
        chk("drain_en", drain_en, e_d);
        chk("busy", busy, e_busy);
        chk("exit", exit, e_exit);
        chk("tile_idx", 32'(tile_idx), m_tidx);
        dut_w += int'(w_ld_en);
        dut_a += int'(act_en);
        dut_d += int'(drain_en);
        if (ctrl_out === 1'b1 && prev_ctrl !== 1'b1) dut_rise++;
        prev_ctrl = ctrl_out;
        if (exit === 1'b1) begin
            dut_exits++;
            dut_exit_cyc = job_cyc;
        end
        @(posedge clk);
        if (abort) ab = 1'b1;
        job_cyc++;
        if (in_job && job_cyc > 3000 && !ab) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got %0d cycles expected at most 3000", job_cyc);
            ab = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic run_job(input int tiles, input int len, input int pw, input int pa,
                           input int po, input int ab_at, input int e_exit,
                           input int e_w, input int e_a, input int e_d);
        int got;
        mod_w = 0; mod_a = 0; mod_d = 0; mod_loads = 0;
        dut_w = 0; dut_a = 0; dut_d = 0; dut_rise = 0; dut_exits = 0; dut_exit_cyc = -1;
        job_cyc = 0; abort_at = ab_at; ab = 1'b0; in_job = 1'b1;
        // Start cycle: scheduler is idle, outputs must be quiet.
        w_valid = coin(pw); act_valid = coin(pa); out_ready = coin(po);
        start = 1'b1;
        cfg_num_tiles = LW'(tiles);
        cfg_act_len = LW'(len);
        cyc(0, 0, 0, 0, 0, 0);
        m_tidx = 0;
        for (int t = 0; t < tiles && !ab; t++) begin
            m_tidx = t;
            mod_loads++;
            got = 0;
            while (got < N && !ab) begin
                drive(pw, pa, po);
                got += int'(w_valid);
                mod_w += int'(w_valid);
                cyc(1, w_valid, 0, 0, 1, 0);
            end
            if (!ab && len == 0) begin
                drive(pw, pa, po);
                cyc(0, 0, 0, 0, 1, 0);
            end
            got = 0;
            while (len > 0 && got < len && !ab) begin
                drive(pw, pa, po);
                got += int'(act_valid);
                mod_a += int'(act_valid);
                cyc(0, 0, act_valid, 0, 1, 0);
            end
            for (int i = 0; i < 2 * N - 1 && !ab; i++) begin
                drive(pw, pa, po);
                cyc(0, 0, 0, 0, 1, 0);
            end
            got = 0;
            while (got < N && !ab) begin
                drive(pw, pa, po);
                got += int'(out_ready);
                mod_d += int'(out_ready);
                cyc(0, 0, 0, out_ready, 1, 0);
            end
        end
        drive(pw, pa, po);
        cyc(0, 0, 0, 0, 1, 1);
        in_job = 1'b0;
        start = 1'b0;
        chk("w_transfers", dut_w, mod_w);
        chk("act_transfers", dut_a, mod_a);
        chk("drain_transfers", dut_d, mod_d);
        chk("ctrl_rises", dut_rise, mod_loads);
        chk("exit_pulses", dut_exits, 1);
        if (e_exit >= 0) chk("exit_cycle", dut_exit_cyc, e_exit);
        if (e_w >= 0) chk("tbl_w", dut_w, e_w);
        if (e_a >= 0) chk("tbl_act", dut_a, e_a);
        if (e_d >= 0) chk("tbl_drain", dut_d, e_d);
    endtask

    initial begin
        // tiles len  pw   pa   po  abort exit  w   a   d
        tbl[0] = '{1, 3, 100, 100, 100, -1, 19, 4, 3, 4};
        tbl[1] = '{3, 2, 100, 100, 100, -1, 52, 12, 6, 12};
        tbl[2] = '{0, 5, 100, 100, 100, -1, 1, 0, 0, 0};
        tbl[3] = '{1, 0, 100, 100, 100, -1, 17, 4, 0, 4};
        tbl[4] = '{1, 3, 100, 100, 100, 6, 7, 4, 2, 0};
        tbl[5] = '{1, 3, 100, 100, 100, -1, 19, 4, 3, 4};
        tbl[6] = '{2, 5, 50, 50, 50, -1, -1, 8, 10, 8};
        tbl[7] = '{3, 1, 50, 50, 50, -1, -1, 12, 3, 12};
        tbl[8] = '{2, 4, 50, 50, 50, 20, -1, -1, -1, -1};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        w_valid = 1'b0; act_valid = 1'b0; out_ready = 1'b0;
        cfg_num_tiles = '0; cfg_act_len = '0;
        m_tidx = 0; job_cyc = 0; abort_at = -1; ab = 1'b0; in_job = 1'b0;
        prev_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        // Start during reset must be ignored.
        start = 1'b1; cfg_num_tiles = LW'(2); cfg_act_len = LW'(3);
        w_valid = 1'b1; act_valid = 1'b1; out_ready = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0; start = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        // Table jobs run back to back: each start lands on the cycle after FIN.
        for (int k = 0; k < 9; k++) begin
            run_job(tbl[k].tiles, tbl[k].len, tbl[k].pw, tbl[k].pa, tbl[k].po,
                    tbl[k].ab_at, tbl[k].e_exit, tbl[k].e_w, tbl[k].e_a, tbl[k].e_d);
        end

        for (int k = 0; k < 8; k++) begin
            run_job($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(30, 100),
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1,
                    -1, -1, -1, -1);
        end

        // Reset in the second tile's DRAIN, with start raised in the same cycle.
        w_valid = 1'b1; act_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1; cfg_num_tiles = LW'(2); cfg_act_len = LW'(1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        #1;
        chk("pre_rst_drain_en", drain_en, 1'b1);
        chk("pre_rst_tile_idx", 32'(tile_idx), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        m_tidx = 0;
        prev_ctrl = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
